// File: rtl/ic_rr_arbiter_if.sv
// Handshake bundle for one interconnect output arbiter:
// NumIn upstream valid/ready streams plus the single downstream port.
interface ic_rr_arbiter_if #(
  parameter int NumIn     = 32,
  parameter int DataWidth = 64
);
  localparam int IdxWidth = $clog2(NumIn);

  logic [NumIn-1:0][DataWidth-1:0] in_data_i;
  logic [NumIn-1:0]                in_last_i;
  logic [NumIn-1:0]                in_valid_i;
  logic [NumIn-1:0]                in_ready_o;
  logic [DataWidth-1:0]            out_data_o;
  logic                            out_last_o;
  logic                            out_valid_o;
  logic                            out_ready_i;
  logic [IdxWidth-1:0]             grant_idx_o;
  logic                            busy_o;

  modport slave (
    input  in_data_i,
    input  in_last_i,
    input  in_valid_i,
    input  out_ready_i,
    output in_ready_o,
    output out_data_o,
    output out_last_o,
    output out_valid_o,
    output grant_idx_o,
    output busy_o
  );

  modport master (
    output in_data_i,
    output in_last_i,
    output in_valid_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_data_o,
    input  out_last_o,
    input  out_valid_o,
    input  grant_idx_o,
    input  busy_o
  );
endinterface

// File: rtl/ic_rr_arbiter.sv
// N:1 round-robin arbiter with packet lock and a
// single-entry output register for one interconnect output.
module ic_rr_arbiter #(
  parameter  int NumIn     = 32,
  parameter  int DataWidth = 64,
  localparam int IdxWidth  = $clog2(NumIn)
) (
  input logic           clk_i,
  input logic           rst_i,
  ic_rr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } state_t;

  localparam logic [IdxWidth:0] NumInW =
    (IdxWidth+1)'(NumIn);
  localparam logic [IdxWidth-1:0] LastIdx =
    IdxWidth'(NumIn - 1);

  state_t              state_q;
  state_t              state_d;
  logic [IdxWidth-1:0] rr_ptr_q;
  logic [IdxWidth-1:0] rr_ptr_d;
  logic [IdxWidth-1:0] lock_idx_q;
  logic [IdxWidth-1:0] lock_idx_d;
  logic [IdxWidth-1:0] winner;
  logic [IdxWidth-1:0] sel_idx;
  logic [IdxWidth-1:0] grant;
  logic [IdxWidth:0]   scan;
  logic                found;
  logic [NumIn-1:0]    ready;
  logic                load_en;
  logic                accept;
  logic                sel_last;
  logic [DataWidth-1:0] sel_data;

  logic                 out_valid_q;
  logic                 out_last_q;
  logic [DataWidth-1:0] out_data_q;

  function automatic logic [IdxWidth-1:0] next_idx(
    input logic [IdxWidth-1:0] i
  );
    return (i == LastIdx) ? '0 : i + 1'b1;
  endfunction

  assign load_en = !out_valid_q || bus.out_ready_i;

  // First valid input at or after rr_ptr, modulo NumIn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    scan   = '0;
    for (int k = 0; k < NumIn; k++) begin
      scan = {1'b0, rr_ptr_q} + (IdxWidth+1)'(k);
      if (scan >= NumInW) begin
        scan = scan - NumInW;
      end
      if (!found &&
          bus.in_valid_i[scan[IdxWidth-1:0]]) begin
        found  = 1'b1;
        winner = scan[IdxWidth-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    sel_idx    = winner;
    grant      = rr_ptr_q;
    ready      = '0;
    unique case (state_q)
      IDLE: begin
        sel_idx = winner;
        if (found) begin
          grant         = winner;
          ready[winner] = load_en;
        end
      end
      LOCKED: begin
        sel_idx           = lock_idx_q;
        grant             = lock_idx_q;
        ready[lock_idx_q] = load_en;
      end
      default: ;
    endcase
    if (rst_i) begin
      ready = '0;
    end
    accept   = |(ready & bus.in_valid_i);
    sel_last = bus.in_last_i[sel_idx];
    sel_data = bus.in_data_i[sel_idx];
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (sel_last) begin
            rr_ptr_d = next_idx(winner);
          end else begin
            state_d    = LOCKED;
            lock_idx_d = winner;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_d  = IDLE;
            rr_ptr_d = next_idx(lock_idx_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Push and pop may coincide; data holds while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_last_q  <= sel_last;
      out_data_q  <= sel_data;
    end else if (bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready_o  = ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_last_o  = out_last_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.grant_idx_o = grant;
  assign bus.busy_o      = (state_q == LOCKED);

endmodule

// File: tb/tb_ic_rr_arbiter.sv
// Directed vector bench for ic_rr_arbiter: per-cycle
// stimulus table plus a full-rotation streaming sequence.
module tb_ic_rr_arbiter;

  localparam int N = 32;
  localparam int W = 64;

  typedef struct {
    logic        rst;
    logic [31:0] vld;
    logic [31:0] lst;
    logic [31:0] tag;
    logic        ordy;
    logic [31:0] rdy;
    logic [4:0]  gnt;
    logic        ovld;
    logic [63:0] odat;
    logic        olast;
    logic        busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[27];

  always #5 clk = ~clk;

  ic_rr_arbiter_if #(
    .NumIn(N),
    .DataWidth(W)
  ) bus ();

  ic_rr_arbiter #(
    .NumIn(N),
    .DataWidth(W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  function automatic logic [31:0] b(input int n);
    return 32'd1 << n;
  endfunction

  function automatic vec_t mk(
    input logic        r,
    input logic [31:0] vl,
    input logic [31:0] ls,
    input logic [31:0] tg,
    input logic        orr,
    input logic [31:0] rd,
    input logic [4:0]  g,
    input logic        ov,
    input logic [31:0] dtag,
    input int          dport,
    input logic        ol,
    input logic        bz
  );
    vec_t v;
    v.rst   = r;
    v.vld   = vl;
    v.lst   = ls;
    v.tag   = tg;
    v.ordy  = orr;
    v.rdy   = rd;
    v.gnt   = g;
    v.ovld  = ov;
    v.odat  = {dtag, 32'(dport)};
    v.olast = ol;
    v.busy  = bz;
    return v;
  endfunction

  task automatic drive(
    input logic        r,
    input logic [31:0] vl,
    input logic [31:0] ls,
    input logic [31:0] tg,
    input logic        orr
  );
    @(negedge clk);
    rst             = r;
    bus.in_valid_i  = vl;
    bus.in_last_i   = ls;
    bus.out_ready_i = orr;
    for (int i = 0; i < N; i++) begin
      bus.in_data_i[i] = {tg, 32'(i)};
    end
    #1;
  endtask

  task automatic check(input string nm, input vec_t e);
    n_vec++;
    if (bus.in_ready_o !== e.rdy) begin
      n_err++;
      $display("FAIL %s in_ready got %h want %h",
               nm, bus.in_ready_o, e.rdy);
    end
    if (bus.grant_idx_o !== e.gnt) begin
      n_err++;
      $display("FAIL %s grant got %0d want %0d",
               nm, bus.grant_idx_o, e.gnt);
    end
    if (bus.out_valid_o !== e.ovld) begin
      n_err++;
      $display("FAIL %s out_valid got %b want %b",
               nm, bus.out_valid_o, e.ovld);
    end
    if (bus.busy_o !== e.busy) begin
      n_err++;
      $display("FAIL %s busy got %b want %b",
               nm, bus.busy_o, e.busy);
    end
    if (e.ovld && bus.out_data_o !== e.odat) begin
      n_err++;
      $display("FAIL %s out_data got %h want %h",
               nm, bus.out_data_o, e.odat);
    end
    if (e.ovld && bus.out_last_o !== e.olast) begin
      n_err++;
      $display("FAIL %s out_last got %b want %b",
               nm, bus.out_last_o, e.olast);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.in_valid_i  = '0;
    bus.in_last_i   = '0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b1;

    // reset, then idle
    vecs[0]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // port 5 four-beat packet, port 6 waiting
    vecs[2]  = mk(0, b(5)|b(6), b(6), 1, 1,
                  b(5), 5, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, b(5)|b(6), b(6), 2, 1,
                  b(5), 5, 1, 1, 5, 0, 1);
    vecs[4]  = mk(0, b(5)|b(6), b(6), 3, 1,
                  b(5), 5, 1, 2, 5, 0, 1);
    vecs[5]  = mk(0, b(5)|b(6), b(5)|b(6), 4, 1,
                  b(5), 5, 1, 3, 5, 0, 1);
    vecs[6]  = mk(0, b(6), b(6), 5, 1,
                  b(6), 6, 1, 4, 5, 1, 0);
    // downstream stall for 3 cycles
    vecs[7]  = mk(0, b(9), b(9), 6, 0,
                  0, 9, 1, 5, 6, 1, 0);
    vecs[8]  = vecs[7];
    vecs[9]  = vecs[7];
    vecs[10] = mk(0, b(9), b(9), 6, 1,
                  b(9), 9, 1, 5, 6, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 1,
                  0, 10, 1, 6, 9, 1, 0);
    vecs[12] = mk(0, 0, 0, 0, 1,
                  0, 10, 0, 0, 0, 0, 0);
    // wrap: 31 wins, then 0 beats 30
    vecs[13] = mk(0, b(31), b(31), 7, 1,
                  b(31), 31, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, b(0)|b(30), b(0)|b(30), 8, 1,
                  b(0), 0, 1, 7, 31, 1, 0);
    vecs[15] = mk(0, b(30), b(30), 9, 1,
                  b(30), 30, 1, 8, 0, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 1,
                  0, 31, 1, 9, 30, 1, 0);
    // reset mid-packet on port 3
    vecs[17] = mk(0, b(3)|b(7), b(7), 10, 1,
                  b(3), 3, 0, 0, 0, 0, 0);
    vecs[18] = mk(0, b(3)|b(7), b(7), 11, 1,
                  b(3), 3, 1, 10, 3, 0, 1);
    vecs[19] = mk(1, b(7), b(7), 12, 1,
                  0, 3, 1, 11, 3, 0, 1);
    vecs[20] = mk(0, b(7), b(7), 13, 1,
                  b(7), 7, 0, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 1,
                  0, 8, 1, 13, 7, 1, 0);
    // lock holds through a bubble on port 2
    vecs[22] = mk(0, b(2), 0, 14, 1,
                  b(2), 2, 0, 0, 0, 0, 0);
    vecs[23] = mk(0, b(4), b(4), 15, 1,
                  b(2), 2, 1, 14, 2, 0, 1);
    vecs[24] = mk(0, b(2)|b(4), b(2)|b(4), 16, 1,
                  b(2), 2, 0, 0, 0, 0, 1);
    vecs[25] = mk(0, b(4), b(4), 17, 1,
                  b(4), 4, 1, 16, 2, 1, 0);
    vecs[26] = mk(0, 0, 0, 0, 1,
                  0, 5, 1, 17, 4, 1, 0);

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].lst,
            vecs[i].tag, vecs[i].ordy);
      check($sformatf("vec%0d", i), vecs[i]);
    end

    // all 32 valid single-beat: 0..31,0 at full rate
    drive(1, 0, 0, 0, 1);
    for (int k = 0; k < 34; k++) begin
      vec_t e;
      drive(0, '1, '1, 0, 1);
      e = mk(0, '1, '1, 0, 1, b(k % 32),
             5'(k % 32), (k > 0), 0,
             (k + 31) % 32, 1, 0);
      check($sformatf("rot%0d", k), e);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
